// File: rtl/sdram_mport_pkg.sv
// Shared types and width helpers for the sdram_mport multi-port front end.
package sdram_mport_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } mport_state_t;

  // ceil(log2(n)), never less than 1 so single-entry ranges still get a bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

  function automatic int id_width(input int np);
    return clog2_min1(np);
  endfunction

  function automatic int out_width(input int max_out);
    return clog2_min1(max_out + 1);
  endfunction

  function automatic int word_width(input int burst);
    return clog2_min1(burst);
  endfunction

  function automatic int next_rr(input int idx, input int np);
    return (idx + 1 >= np) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sdram_mport_rsp.sv
// Per-port read-return tracker: burst word counter, outstanding-read counter,
// registered rd_last and this port's protocol-error contribution.
module sdram_mport_rsp
  import sdram_mport_pkg::*;
#(
  parameter int BURST   = 8,
  parameter int MAX_OUT = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic inc,
  input  logic word_valid,
  output logic can_read,
  output logic rd_last,
  output logic err_hit
);

  localparam int OW = out_width(MAX_OUT);
  localparam int WW = word_width(BURST);

  logic [OW-1:0] out_q, out_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic          rd_last_q, rd_last_d;
  logic          last_word;
  logic          dec;

  always_comb begin
    last_word = word_valid && (cnt_q == WW'(BURST - 1));
    // outstanding saturates at zero when a burst ends with nothing owed
    dec       = last_word && (out_q != '0);
    err_hit   = word_valid && (out_q == '0) && (cnt_q == '0);
    can_read  = (out_q < OW'(MAX_OUT));
    rd_last_d = last_word;

    cnt_d = cnt_q;
    if (word_valid) begin
      cnt_d = last_word ? '0 : cnt_q + WW'(1);
    end

    case ({inc, dec})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      out_q     <= '0;
      cnt_q     <= '0;
      rd_last_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      rd_last_q <= rd_last_d;
    end
  end

  assign rd_last = rd_last_q;

endmodule

// File: rtl/sdram_mport.sv
// N-port arbiter and read-return router in front of the SDRAM controller.
// Optional SDRAM_MPORT_PRIO_EN gives port 0 fixed top priority over round-robin.
module sdram_mport
  import sdram_mport_pkg::*;
#(
  parameter  int NP      = 4,
  parameter  int AN      = 24,
  parameter  int DN      = 16,
  parameter  int BURST   = 8,
  parameter  int MAX_OUT = 2,
  localparam int IN      = id_width(NP)
) (
  input  logic             clkSYS,
  input  logic             reset,
  input  logic [NP*AN-1:0] port_addr,
  input  logic [NP*DN-1:0] port_data,
  input  logic [NP-1:0]    port_req,
  input  logic [NP-1:0]    port_wr,
  output logic [NP-1:0]    port_ack,
  output logic [DN-1:0]    rd_data,
  output logic [NP-1:0]    rd_valid,
  output logic [NP-1:0]    rd_last,
  output logic [AN-1:0]    req_addr,
  output logic [DN-1:0]    req_data,
  output logic [IN-1:0]    req_id,
  output logic             req,
  output logic             req_wr,
  input  logic             req_ack,
  input  logic [DN-1:0]    mem_data,
  input  logic [IN-1:0]    mem_id,
  input  logic             mem_valid,
  output logic             err
);

  mport_state_t state_q, state_d;
  logic [IN-1:0] rr_q, rr_d;
  logic [IN-1:0] req_id_q, req_id_d;
  logic [AN-1:0] req_addr_q, req_addr_d;
  logic [DN-1:0] req_data_q, req_data_d;
  logic          req_q, req_d;
  logic          req_wr_q, req_wr_d;
  logic [NP-1:0] port_ack_q, port_ack_d;
  logic [DN-1:0] rd_data_q, rd_data_d;
  logic [NP-1:0] rd_valid_q, rd_valid_d;
  logic          err_q, err_d;

  logic [NP-1:0]   eligible, elig_rr, can_read, err_hit, inc_vec, word_vec;
  logic [2*NP-1:0] rot;
  logic            found;
  logic [IN-1:0]   gsel;

  always_comb begin
    int sel_idx;
    eligible = port_req & (port_wr | can_read);
    elig_rr  = eligible;
`ifdef SDRAM_MPORT_PRIO_EN
    elig_rr[0] = 1'b0;
`endif
    // rot[k] is the eligibility of port (rr_q + k) mod NP
    rot     = {elig_rr, elig_rr} >> rr_q;
    found   = 1'b0;
    gsel    = '0;
    sel_idx = 0;
    for (int k = NP - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found   = 1'b1;
        sel_idx = int'(rr_q) + k;
        if (sel_idx >= NP) sel_idx = sel_idx - NP;
        gsel = IN'(sel_idx);
      end
    end
`ifdef SDRAM_MPORT_PRIO_EN
    if (eligible[0]) begin
      found = 1'b1;
      gsel  = '0;
    end
`endif

    state_d    = state_q;
    rr_d       = rr_q;
    req_d      = req_q;
    req_id_d   = req_id_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_wr_d   = req_wr_q;
    port_ack_d = '0;
    inc_vec    = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = ISSUE;
          req_d    = 1'b1;
          req_id_d = gsel;
          for (int p = 0; p < NP; p++) begin
            if (gsel == IN'(p)) begin
              req_addr_d    = port_addr[p*AN +: AN];
              req_data_d    = port_data[p*DN +: DN];
              req_wr_d      = port_wr[p];
              port_ack_d[p] = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (req_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
`ifdef SDRAM_MPORT_PRIO_EN
          if (req_id_q != '0) rr_d = IN'(next_rr(int'(req_id_q), NP));
`else
          rr_d = IN'(next_rr(int'(req_id_q), NP));
`endif
          for (int p = 0; p < NP; p++) begin
            inc_vec[p] = !req_wr_q && (req_id_q == IN'(p));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    for (int p = 0; p < NP; p++) begin
      word_vec[p] = mem_valid && (mem_id == IN'(p));
    end
    rd_valid_d = word_vec;
    rd_data_d  = (|word_vec) ? mem_data : rd_data_q;
    err_d      = err_q | (mem_valid && !(|word_vec)) | (|err_hit);
  end

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      req_q      <= 1'b0;
      req_id_q   <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_wr_q   <= 1'b0;
      port_ack_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      req_q      <= req_d;
      req_id_q   <= req_id_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_wr_q   <= req_wr_d;
      port_ack_q <= port_ack_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  for (genvar gi = 0; gi < NP; gi++) begin : g_rsp
    sdram_mport_rsp #(
      .BURST  (BURST),
      .MAX_OUT(MAX_OUT)
    ) u_rsp (
      .clk       (clkSYS),
      .srst      (reset),
      .inc       (inc_vec[gi]),
      .word_valid(word_vec[gi]),
      .can_read  (can_read[gi]),
      .rd_last   (rd_last[gi]),
      .err_hit   (err_hit[gi])
    );
  end

  assign port_ack = port_ack_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign req_addr = req_addr_q;
  assign req_data = req_data_q;
  assign req_id   = req_id_q;
  assign req      = req_q;
  assign req_wr   = req_wr_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sdram_mport.sv
// Directed bench for sdram_mport: arbitration, routing, throttling, errors.
module tb_sdram_mport;
  localparam int NP = 4;
  localparam int AN = 24;
  localparam int DN = 16;
  localparam int IN = 2;

  logic             clkSYS = 1'b0;
  logic             reset;
  logic [NP*AN-1:0] port_addr;
  logic [NP*DN-1:0] port_data;
  logic [NP-1:0]    port_req, port_wr, port_ack, rd_valid, rd_last;
  logic [DN-1:0]    rd_data, req_data, mem_data;
  logic [AN-1:0]    req_addr;
  logic [IN-1:0]    req_id, mem_id;
  logic             req, req_wr, req_ack, mem_valid, err;

  int checks = 0;
  int errors = 0;

  sdram_mport #(.NP(NP), .AN(AN), .DN(DN), .BURST(8), .MAX_OUT(2)) dut (
    .clkSYS(clkSYS), .reset(reset), .port_addr(port_addr), .port_data(port_data),
    .port_req(port_req), .port_wr(port_wr), .port_ack(port_ack), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .req_addr(req_addr), .req_data(req_data),
    .req_id(req_id), .req(req), .req_wr(req_wr), .req_ack(req_ack),
    .mem_data(mem_data), .mem_id(mem_id), .mem_valid(mem_valid), .err(err)
  );

  always #5 clkSYS = ~clkSYS;

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clkSYS);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; port_req = '0; port_wr = '0; port_addr = '0; port_data = '0;
    req_ack = 1'b0; mem_valid = 1'b0; mem_id = '0; mem_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({req, req_wr, port_ack, rd_valid, rd_last, err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b wr=%b ack=%b rv=%b rl=%b err=%b required all 0",
               req, req_wr, port_ack, rd_valid, rd_last, err);
    end
    checks++;
    if ({req_addr, req_data, req_id, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h data=%h id=%0d rd=%h required 0",
               req_addr, req_data, req_id, rd_data);
    end
    $display("reset checked");
  endtask

  task automatic test_write;
    do_reset();
    port_addr[2*AN +: AN] = 24'h123456;
    port_data[2*DN +: DN] = 16'hBEEF;
    port_wr[2] = 1'b1; port_req[2] = 1'b1;
    tick();
    port_req[2] = 1'b0;
    checks++;
    if ({req, req_wr, req_id, port_ack} !== {1'b1, 1'b1, 2'd2, 4'b0100}) begin
      errors++;
      $display("FAIL wr_grant got req=%b wr=%b id=%0d ack=%b required 1 1 2 0100",
               req, req_wr, req_id, port_ack);
    end
    checks++;
    if ({req_addr, req_data} !== {24'h123456, 16'hBEEF}) begin
      errors++;
      $display("FAIL wr_payload got %h/%h required 123456/beef", req_addr, req_data);
    end
    tick();
    checks++;
    if ({req, port_ack, req_addr, req_id} !== {1'b1, 4'b0000, 24'h123456, 2'd2}) begin
      errors++;
      $display("FAIL wr_hold got req=%b ack=%b addr=%h id=%0d required 1 0000 123456 2",
               req, port_ack, req_addr, req_id);
    end
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL wr_release got req=%b required 0", req);
    end
    $display("write port 2 addr %h data %h", 24'h123456, 16'hBEEF);
  endtask

  task automatic test_round_robin;
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    do_reset();
    port_req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      logic [NP-1:0] exp_ack;
      exp_ack = 4'b0001 << exp_seq[i];
      tick();
      checks++;
      if ({req, req_id, port_ack} !== {1'b1, 2'(exp_seq[i]), exp_ack}) begin
        errors++;
        $display("FAIL rr_grant%0d got req=%b id=%0d ack=%b required 1 %0d %b",
                 i, req, req_id, port_ack, exp_seq[i], exp_ack);
      end
      $display("grant port %0d", req_id);
      port_req[exp_seq[i]] = 1'b0;
      if (i == 3) port_req[0] = 1'b1;
      req_ack = 1'b1;
      tick();
      req_ack = 1'b0;
      checks++;
      if (req !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d got req=%b required 0", i, req);
      end
    end
    port_req = '0;
  endtask

  task automatic test_burst;
    do_reset();
    port_req[1] = 1'b1;
    tick();
    port_req[1] = 1'b0;
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    for (int w = 0; w < 8; w++) begin
      logic [NP-1:0] exp_last;
      exp_last = (w == 7) ? 4'b0010 : 4'b0000;
      mem_valid = 1'b1; mem_id = 2'd1; mem_data = 16'h1000 + 16'(w);
      if (w == 0) begin
        checks++;
        if (rd_valid !== 4'b0000) begin
          errors++;
          $display("FAIL burst_latency got rd_valid=%b required 0000", rd_valid);
        end
      end
      tick();
      checks++;
      if ({rd_valid, rd_last, rd_data} !== {4'b0010, exp_last, 16'h1000 + 16'(w)}) begin
        errors++;
        $display("FAIL burst_word%0d got rv=%b rl=%b data=%h required 0010 %b %h",
                 w, rd_valid, rd_last, rd_data, exp_last, 16'h1000 + 16'(w));
      end
      $display("word %0d port 1 data %h last %b", w, rd_data, rd_last[1]);
    end
    mem_valid = 1'b0;
    tick();
    checks++;
    if ({rd_valid, rd_last, err} !== {4'b0000, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL burst_end got rv=%b rl=%b err=%b required 0000 0000 0",
               rd_valid, rd_last, err);
    end
  endtask

  task automatic test_max_out;
    do_reset();
    port_req[3] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({req, req_id} !== {1'b1, 2'd3}) begin
        errors++;
        $display("FAIL mo_read%0d got req=%b id=%0d required 1 3", i, req, req_id);
      end
      $display("grant port %0d read %0d", req_id, i);
      req_ack = 1'b1;
      tick();
      req_ack = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({req, port_ack} !== {1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL mo_throttle%0d got req=%b ack=%b required 0 0000", i, req, port_ack);
      end
    end
    port_req[0] = 1'b1; port_wr[0] = 1'b1;
    tick();
    checks++;
    if ({req, req_id, req_wr} !== {1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL mo_write got req=%b id=%0d wr=%b required 1 0 1", req, req_id, req_wr);
    end
    port_req[0] = 1'b0;
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    for (int w = 0; w < 8; w++) begin
      mem_valid = 1'b1; mem_id = 2'd3; mem_data = 16'hA000 + 16'(w);
      tick();
      checks++;
      if ({req, rd_valid} !== {1'b0, 4'b1000}) begin
        errors++;
        $display("FAIL mo_word%0d got req=%b rv=%b required 0 1000", w, req, rd_valid);
      end
    end
    mem_valid = 1'b0;
    tick();
    checks++;
    if ({req, req_id, port_ack} !== {1'b1, 2'd3, 4'b1000}) begin
      errors++;
      $display("FAIL mo_third got req=%b id=%0d ack=%b required 1 3 1000", req, req_id, port_ack);
    end
    $display("grant port %0d third read", req_id);
    port_req = '0;
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
  endtask

  task automatic test_err_reset;
    do_reset();
    mem_valid = 1'b1; mem_id = 2'd0; mem_data = 16'h5A5A;
    tick();
    mem_valid = 1'b0;
    checks++;
    if ({rd_valid, rd_data, err} !== {4'b0001, 16'h5A5A, 1'b1}) begin
      errors++;
      $display("FAIL stray_word got rv=%b data=%h err=%b required 0001 5a5a 1", rd_valid, rd_data, err);
    end
    tick();
    checks++;
    if ({rd_valid, err} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL err_sticky got rv=%b err=%b required 0000 1", rd_valid, err);
    end
    port_req[2] = 1'b1;
    tick();
    port_req[2] = 1'b0;
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_req got req=%b required 1", req);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({req, err, port_ack} !== {1'b0, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL mid_reset got req=%b err=%b ack=%b required 0 0 0000", req, err, port_ack);
    end
    $display("stray word and mid-issue reset");
  endtask

  task automatic test_back_to_back;
    int exp_seq[4];
`ifdef SDRAM_MPORT_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 2, 0, 2};
`endif
    do_reset();
    port_wr = 4'b0101; port_req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({req, req_id} !== {1'b1, 2'(exp_seq[i])}) begin
        errors++;
        $display("FAIL b2b_grant%0d got req=%b id=%0d required 1 %0d", i, req, req_id, exp_seq[i]);
      end
      $display("grant port %0d", req_id);
      req_ack = 1'b1;
      tick();
      req_ack = 1'b0;
    end
    port_req = '0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_burst();
    test_max_out();
    test_err_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
